// File: rtl/perceptron_host_driver.sv
// Host-side initiator for the perceptron core: sends a header plus N_FEAT feature
// bytes over a valid/ready link, then waits for the core's result byte or a timeout.
module perceptron_host_driver #(
  parameter int N_FEAT  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*N_FEAT-1:0]   feat_in,
  output logic                  busy,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            result,
  output logic                  result_valid,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_FEAT, WAIT_RES} state_t;

  localparam logic [7:0] HDR_BYTE = {4'hA, 4'(N_FEAT)};
  localparam logic [3:0] IDX_LAST = 4'(N_FEAT - 1);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_reg, state_next;
  logic [8*N_FEAT-1:0]   shadow_reg, shadow_next;
  logic [7:0]            tx_data_reg, tx_data_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic [3:0]            idx_reg, idx_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [7:0]            result_reg, result_next;
  logic                  result_valid_reg, result_valid_next;
  logic                  timeout_reg, timeout_next;
  logic                  busy_reg, busy_next;
  logic                  xfer;

  assign xfer = tx_valid_reg && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      shadow_reg       <= '0;
      tx_data_reg      <= 8'd0;
      tx_valid_reg     <= 1'b0;
      idx_reg          <= 4'd0;
      cnt_reg          <= 8'd0;
      result_reg       <= 8'd0;
      result_valid_reg <= 1'b0;
      timeout_reg      <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      shadow_reg       <= shadow_next;
      tx_data_reg      <= tx_data_next;
      tx_valid_reg     <= tx_valid_next;
      idx_reg          <= idx_next;
      cnt_reg          <= cnt_next;
      result_reg       <= result_next;
      result_valid_reg <= result_valid_next;
      timeout_reg      <= timeout_next;
      busy_reg         <= busy_next;
    end
  end

  // The shadow acts as a shift register: the next feature byte is always in its low byte.
  always_comb begin
    state_next        = state_reg;
    shadow_next       = shadow_reg;
    tx_data_next      = tx_data_reg;
    tx_valid_next     = tx_valid_reg;
    idx_next          = idx_reg;
    cnt_next          = cnt_reg;
    result_next       = result_reg;
    result_valid_next = 1'b0;
    timeout_next      = 1'b0;
    busy_next         = 1'b1;

    unique case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          shadow_next   = feat_in;
          tx_data_next  = HDR_BYTE;
          tx_valid_next = 1'b1;
          busy_next     = 1'b1;
          state_next    = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (xfer) begin
          tx_data_next = shadow_reg[7:0];
          shadow_next  = shadow_reg >> 8;
          idx_next     = 4'd0;
          state_next   = SEND_FEAT;
        end
      end
      SEND_FEAT: begin
        if (xfer) begin
          if (idx_reg != IDX_LAST) begin
            idx_next     = idx_reg + 4'd1;
            tx_data_next = shadow_reg[7:0];
            shadow_next  = shadow_reg >> 8;
          end else begin
            tx_valid_next = 1'b0;
            cnt_next      = 8'd0;
            state_next    = WAIT_RES;
          end
        end
      end
      WAIT_RES: begin
        // busy stays high through the pulse cycle, so it is left at its default here.
        if (rx_valid) begin
          result_next       = rx_data;
          result_valid_next = 1'b1;
          state_next        = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy         = busy_reg;
  assign tx_data      = tx_data_reg;
  assign tx_valid     = tx_valid_reg;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign timeout      = timeout_reg;

endmodule
